// File: rtl/deco_s_m.sv
// Binary (0..59) to packed-BCD decoder for seconds/minutes, registered output.
// Latency: one clock edge from Ref to Dato_out; no combinational path through.
// No handshake: a new value is accepted and converted every cycle.
module deco_s_m (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] Ref,
  output logic [7:0] Dato_out
);

  logic [2:0] w_tens;
  logic [3:0] w_sub_lo;
  logic [3:0] w_units;
  logic       w_invalid;
  logic [7:0] w_bcd;
  logic [7:0] r_dato;

  // Tens digit by threshold compare; also pick the low nibble of tens*10.
  // The units result is always below 10, so working modulo 16 is exact.
  always_comb begin
    w_tens   = 3'd0;
    w_sub_lo = 4'd0;
    if (Ref >= 6'd50) begin
      w_tens   = 3'd5;
      w_sub_lo = 4'd2;   // 50 mod 16
    end else if (Ref >= 6'd40) begin
      w_tens   = 3'd4;
      w_sub_lo = 4'd8;   // 40 mod 16
    end else if (Ref >= 6'd30) begin
      w_tens   = 3'd3;
      w_sub_lo = 4'd14;  // 30 mod 16
    end else if (Ref >= 6'd20) begin
      w_tens   = 3'd2;
      w_sub_lo = 4'd4;   // 20 mod 16
    end else if (Ref >= 6'd10) begin
      w_tens   = 3'd1;
      w_sub_lo = 4'd10;  // 10 mod 16
    end
  end

  assign w_units   = Ref[3:0] - w_sub_lo;
  assign w_invalid = (Ref > 6'd59);

  // Out-of-range codes load the invalid marker rather than wrapping.
  assign w_bcd = w_invalid ? 8'hFF : {1'b0, w_tens, w_units};

  // Output register: cleared asynchronously, loads the conversion each edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_dato <= 8'h00;
    end else begin
      r_dato <= w_bcd;
    end
  end

  assign Dato_out = r_dato;

endmodule

// File: tb/tb_deco_s_m.sv
// Directed bench for deco_s_m with an expected-value queue.
// Expected codes come from a div/mod reference model of the decode.
// Outputs are sampled 1 ns after the rising edge or mid-cycle.
module tb_deco_s_m;

  logic       Clock;
  logic       Reset;
  logic [5:0] Ref;
  logic [7:0] Dato_out;

  int vectors;
  int miscompares;
  logic [7:0] sb[$];

  deco_s_m dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Ref      (Ref),
    .Dato_out (Dato_out)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] model(input int v);
    int t;
    int u;
    if (v > 59) return 8'hFF;
    t = v / 10;
    u = v % 10;
    return 8'((t << 4) | u);
  endfunction

  task automatic check(input string tag, input logic [7:0] exp);
    vectors++;
    assert (Dato_out === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, Dato_out, exp);
      end
  endtask

  // Drive one value between edges, then compare one edge later.
  task automatic step(input string tag, input int v);
    logic [7:0] exp;
    @(negedge Clock);
    Ref = 6'(v);
    sb.push_back(model(v));
    @(posedge Clock);
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      check(tag, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset       = 1'b1;
    Ref         = 6'd0;

    // Held in reset with the clock running.
    repeat (10) begin
      @(negedge Clock);
      check("reset_hold", 8'h00);
    end
    Reset = 1'b0;
    #1;
    check("post_release_pre_edge", 8'h00);
    step("first_edge_ref0", 0);

    // Exhaustive sweep, a new value every cycle.
    for (int i = 0; i < 64; i++) begin
      step($sformatf("sweep_%0d", i), i);
    end

    // Digit boundaries.
    step("bnd_9", 9);
    step("bnd_10", 10);
    step("bnd_19", 19);
    step("bnd_20", 20);
    step("bnd_49", 49);
    step("bnd_50", 50);
    step("bnd_59", 59);

    // Out-of-range entry and exit.
    step("oor_59", 59);
    step("oor_60", 60);
    step("oor_0", 0);
    step("oor_63", 63);
    step("oor_back_1", 1);

    // Constant input holds the output.
    step("hold_a", 27);
    step("hold_b", 27);
    step("hold_c", 27);

    // Asynchronous reset between edges.
    step("pre_reset_45", 45);
    #2;
    Reset = 1'b1;
    #1;
    check("async_clear", 8'h00);
    @(posedge Clock);
    #1;
    check("reset_hold_edge", 8'h00);
    @(negedge Clock);
    Reset = 1'b0;
    Ref   = 6'd12;
    #1;
    check("release_pre_edge", 8'h00);
    sb.push_back(model(12));
    @(posedge Clock);
    #1;
    check("release_first_edge", sb.pop_front());

    // Latency: mid-cycle input change is not visible until the next edge.
    step("lat_base", 0);
    @(negedge Clock);
    Ref = 6'd33;
    sb.push_back(model(33));
    #1;
    check("lat_no_comb", 8'h00);
    @(posedge Clock);
    #1;
    check("lat_edge", sb.pop_front());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/deco_s_m.md
DECO_S_M -- requirements
Module: deco_s_m

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset:
- Clock  input  1  rising-edge system clock; all state changes occur on this edge except reset.
- Reset  input  1  asynchronous, active-high reset.
REQ-002 Ref  input  6  SHALL carry the unsigned binary seconds/minutes value to decode; the valid range is 0..59.
REQ-003 Dato_out  output  8  SHALL carry the registered packed-BCD result: [7:4] tens digit, [3:0] units digit.
REQ-004 The block SHALL have no parameters and no other ports.

Function
REQ-005 On each rising Clock edge with Reset low, Dato_out SHALL load the conversion of the Ref value sampled at that edge.
REQ-006 Latency SHALL be exactly one clock edge; there SHALL be no combinational path from Ref to Dato_out.
REQ-007 For Ref in 0..59, Dato_out[7:4] SHALL equal Ref div 10 (range 0..5).
REQ-008 For Ref in 0..59, Dato_out[3:0] SHALL equal Ref mod 10 (range 0..9).
REQ-009 For Ref in 0..59, Dato_out[7] SHALL be 0.
REQ-010 For Ref in 60..63 (out of range), Dato_out SHALL load 8'hFF as an invalid marker; the value SHALL NOT wrap or clamp.
REQ-011 The conversion SHALL be purely combinational ahead of the output register, by lookup or arithmetic, with no multi-cycle iteration.
REQ-012 The block SHALL have no handshake and no state other than the Dato_out register.
REQ-013 If Ref is held constant, Dato_out SHALL remain constant from the first edge after the change.
REQ-014 If Ref changes every cycle, each edge SHALL reflect the Ref present at that edge, with no skipped or stale values.
REQ-015 Boundary codes:
- Ref=9 -> 8'h09
- Ref=10 -> 8'h10
- Ref=59 -> 8'h59
- Ref=60 -> 8'hFF
- Ref=63 -> 8'hFF

Reset
REQ-016 While Reset is high, Dato_out SHALL be 8'h00, independent of Clock and Ref.
REQ-017 Reset assertion SHALL clear Dato_out immediately, without waiting for a clock edge, including mid-operation.
REQ-018 After Reset is deasserted, Dato_out SHALL hold 8'h00 until the first rising Clock edge. That edge SHALL load the conversion of the current Ref.
REQ-019 Reset deassertion SHALL be treated as synchronous to Clock by the integrating design; the block adds no reset synchronizer.

Verification
REQ-020 Reset/idle: Reset=1 for 100 ns with Clock toggling and Ref=0, then Reset=0 -> Dato_out=8'h00 throughout; after the first edge it is still 8'h00 (the conversion of Ref=0).
REQ-021 Exhaustive sweep: Ref=0..63, one value per cycle -> each result appears one edge later.
- Ref 0..59: Dato_out = {Ref div 10, Ref mod 10}, e.g. 37 -> 8'h37.
- Ref 60..63: Dato_out = 8'hFF.
REQ-022 Digit boundaries: Ref sequence 9, 10, 19, 20, 49, 50, 59 -> Dato_out 8'h09, 8'h10, 8'h19, 8'h20, 8'h49, 8'h50, 8'h59 on successive edges.
REQ-023 Out-of-range transitions: Ref 59 -> 60 -> 0 -> Dato_out 8'h59, 8'hFF, 8'h00.
REQ-024 Async reset mid-stream: with Dato_out=8'h45, assert Reset between edges -> Dato_out=8'h00 before the next edge; it stays 8'h00 while Reset is high; after release it follows Ref on the next edge.
REQ-025 Latency check: change Ref between edges (for example, 0 to 33) -> Dato_out does not change until the next rising edge, then becomes 8'h33.
